// File: rtl/match_referee_pkg.sv
// ============================================================================
// match_referee_pkg : shared state and winner encodings for the referee slice
// Rev 1.0
// ============================================================================
`default_nettype none

package match_referee_pkg;

    localparam logic [1:0] ST_PLAY  = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_MATCH = 2'd2;

    typedef enum logic [1:0] {
        PLAY  = ST_PLAY,
        HOLD  = ST_HOLD,
        MATCH = ST_MATCH
    } state_e;

    // Winner encoding shared with the playfield and score display blocks
    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] RWIN = 2'b01;
    localparam logic [1:0] LWIN = 2'b10;

endpackage

`default_nettype wire

// File: rtl/match_referee_hold_timer.sv
// ============================================================================
// hold_timer : loadable down-counter that sticks at zero and flags expiry
// Rev 1.0
// ============================================================================
`default_nettype none

module hold_timer #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign expired = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/match_referee.sv
// ============================================================================
// match_referee : round winner detection, result hold, scores and match end
// Rev 1.0
// ============================================================================
`default_nettype none

module match_referee
    import match_referee_pkg::*;
#(
    parameter int WIN_ROUNDS  = 7,
    parameter int HOLD_CYCLES = 4,
    parameter int SCORE_W     = $clog2(WIN_ROUNDS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               L,
    input  logic               R,
    input  logic               LM,
    input  logic               RM,
    output logic [1:0]         winner,
    output logic [1:0]         match_winner,
    output logic [SCORE_W-1:0] l_score,
    output logic [SCORE_W-1:0] r_score,
    output logic               field_reset,
    output logic               match_over
);

    localparam int                 HOLD_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0]  c_hold_ld  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] c_last_rnd = SCORE_W'(WIN_ROUNDS - 1);

    state_e r_state;
    logic   w_lwin;
    logic   w_rwin;
    logic   w_load;
    logic   w_expired;

    assign w_lwin = L & LM & ~R;
    assign w_rwin = R & RM & ~L;
    // Loading on a match-deciding win is harmless: the counter is unused in MATCH
    assign w_load = (r_state == PLAY) & (w_lwin | w_rwin);

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (HOLD_W)
    ) u_hold_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (c_hold_ld),
        .expired  (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= PLAY;
            winner       <= NONE;
            match_winner <= NONE;
            l_score      <= '0;
            r_score      <= '0;
            field_reset  <= 1'b0;
            match_over   <= 1'b0;
        end else begin
            field_reset <= 1'b0;
            case (r_state)
                PLAY: begin
                    if (w_lwin) begin
                        winner  <= LWIN;
                        l_score <= l_score + SCORE_W'(1);
                        if (l_score == c_last_rnd) begin
                            match_winner <= LWIN;
                            match_over   <= 1'b1;
                            r_state      <= MATCH;
                        end else begin
                            r_state <= HOLD;
                        end
                    end else if (w_rwin) begin
                        winner  <= RWIN;
                        r_score <= r_score + SCORE_W'(1);
                        if (r_score == c_last_rnd) begin
                            match_winner <= RWIN;
                            match_over   <= 1'b1;
                            r_state      <= MATCH;
                        end else begin
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_expired) begin
                        winner      <= NONE;
                        field_reset <= 1'b1;
                        r_state     <= PLAY;
                    end
                end
                MATCH: begin
                end
                default: r_state <= PLAY;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_match_referee.sv
// ============================================================================
// tb_match_referee : directed self-checking bench, WIN_ROUNDS=3, HOLD_CYCLES=4
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_match_referee;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       L = 1'b0, R = 1'b0, LM = 1'b0, RM = 1'b0;
    logic [1:0] winner, match_winner;
    logic [1:0] l_score, r_score;
    logic       field_reset, match_over;

    int checks = 0;
    int errors = 0;

    match_referee #(
        .WIN_ROUNDS  (3),
        .HOLD_CYCLES (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .L            (L),
        .R            (R),
        .LM           (LM),
        .RM           (RM),
        .winner       (winner),
        .match_winner (match_winner),
        .l_score      (l_score),
        .r_score      (r_score),
        .field_reset  (field_reset),
        .match_over   (match_over)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic l, input logic r, input logic lm, input logic rm);
        L = l; R = r; LM = lm; RM = rm;
        tick();
        L = 1'b0; R = 1'b0; LM = 1'b0; RM = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs all outputs: {match_over, field_reset, match_winner, winner, ...}
    function automatic logic [11:0] outs();
        return {match_over, field_reset, match_winner, winner, l_score, r_score};
    endfunction

    task automatic chk_all(input string tag, input logic [11:0] exp);
        checks++;
        assert (outs() === exp) else begin
            errors++;
            $error("FAIL %s: observed %03h expected %03h", tag, outs(), exp);
        end
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk_all("reset_state", 12'h000);

        // Simultaneous presses never win
        press(1, 1, 1, 1);
        chk_all("both_pressed", 12'h000);

        // Presses away from the player's end
        press(1, 0, 0, 0);
        chk_all("l_no_lm", 12'h000);
        press(0, 1, 0, 0);
        chk_all("r_no_rm", 12'h000);
        press(1, 0, 0, 1);
        chk_all("l_with_rm", 12'h000);

        // Left round win, presses during HOLD ignored, hold lasts 4 cycles
        press(1, 0, 1, 0);
        chk("lwin_winner", 8'(winner), 8'h2);
        chk("lwin_lscore", 8'(l_score), 8'h1);
        chk("lwin_no_fr", 8'(field_reset), 8'h0);
        for (int j = 1; j <= 3; j++) begin
            L = 1'b1; LM = 1'b1;
            tick();
            chk("hold_winner", 8'(winner), 8'h2);
            chk("hold_lscore", 8'(l_score), 8'h1);
            chk("hold_no_fr", 8'(field_reset), 8'h0);
        end
        L = 1'b0; LM = 1'b0;
        tick();
        chk_all("hold_end", {1'b0, 1'b1, 2'b00, 2'b00, 2'd1, 2'd0});
        tick();
        chk_all("fr_one_cycle", {1'b0, 1'b0, 2'b00, 2'b00, 2'd1, 2'd0});

        // Right round 1
        press(0, 1, 0, 1);
        chk_all("r1_win", {1'b0, 1'b0, 2'b00, 2'b01, 2'd1, 2'd1});
        for (int j = 0; j < 3; j++) tick();
        chk("r1_still_held", 8'(winner), 8'h1);
        tick();
        chk_all("r1_release", {1'b0, 1'b1, 2'b00, 2'b00, 2'd1, 2'd1});

        // Right round 2 pressed in the field_reset cycle
        press(0, 1, 0, 1);
        chk_all("r2_win", {1'b0, 1'b0, 2'b00, 2'b01, 2'd1, 2'd2});
        for (int j = 0; j < 4; j++) tick();
        chk_all("r2_release", {1'b0, 1'b1, 2'b00, 2'b00, 2'd1, 2'd2});
        tick();

        // Right round 3 decides the match
        press(0, 1, 0, 1);
        chk_all("match_win", {1'b1, 1'b0, 2'b01, 2'b01, 2'd1, 2'd3});
        for (int j = 0; j < 6; j++) begin
            if (j % 2 == 0) press(1, 0, 1, 0);
            else press(0, 1, 0, 1);
            chk_all("match_frozen", {1'b1, 1'b0, 2'b01, 2'b01, 2'd1, 2'd3});
        end

        // Reset out of MATCH
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all("reset_from_match", 12'h000);

        // Reset mid-HOLD clears everything and suppresses field_reset
        press(1, 0, 1, 0);
        chk_all("pre_reset_lwin", {1'b0, 1'b0, 2'b00, 2'b10, 2'd1, 2'd0});
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all("reset_mid_hold", 12'h000);
        for (int j = 0; j < 4; j++) begin
            tick();
            chk_all("no_fr_after_reset", 12'h000);
        end
        press(1, 0, 1, 0);
        chk_all("lwin_after_reset", {1'b0, 1'b0, 2'b00, 2'b10, 2'd1, 2'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
